// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: walks the output tiles of Y[M,N] = X[M,K] * W[K,N] and issues
// one job per ARRAY_ROW x ARRAY_COL tile to the per-tile controller. Tiles are issued
// n-outer, m-inner so that a weight tile is reused across consecutive row tiles.
// Addresses advance incrementally; the only multiplies happen once per job, in LATCH.
//
// Handshake: tile_start is a one-cycle pulse raised while every tile_* output is already
// stable. The scheduler then waits for a one-cycle tile_done pulse. A tile_done pulse that
// arrives in any state other than WAIT, including the ISSUE cycle itself, is dropped.
//
// Optional build macro: SCHED_PERF_CNT_EN adds the perf_busy_cycles and perf_tiles counters.
module gemm_tile_scheduler #(
    parameter int ARRAY_ROW = 16,
    parameter int ARRAY_COL = 16,
    parameter int DIM_W     = 16,
    parameter int ADDR_W    = 32,
    localparam int RV_W     = $clog2(ARRAY_ROW + 1),
    localparam int CV_W     = $clog2(ARRAY_COL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ap_start,
    input  logic [DIM_W-1:0]  cfg_m_dim,
    input  logic [DIM_W-1:0]  cfg_n_dim,
    input  logic [DIM_W-1:0]  cfg_k_dim,
    input  logic [ADDR_W-1:0] cfg_x_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_y_base,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              tile_start,
    input  logic              tile_done,
    output logic [DIM_W-1:0]  tile_k_dim,
    output logic [DIM_W-1:0]  tile_m_idx,
    output logic [DIM_W-1:0]  tile_n_idx,
    output logic [ADDR_W-1:0] tile_x_addr,
    output logic [ADDR_W-1:0] tile_w_addr,
    output logic [ADDR_W-1:0] tile_y_addr,
    output logic [RV_W-1:0]   tile_rows_valid,
    output logic [CV_W-1:0]   tile_cols_valid,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]       perf_busy_cycles,
    output logic [DIM_W-1:0]  perf_tiles,
`endif
    output logic [2:0]        sched_state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [DIM_W-1:0]  ROW_D = DIM_W'(ARRAY_ROW);
    localparam logic [DIM_W-1:0]  COL_D = DIM_W'(ARRAY_COL);
    localparam logic [ADDR_W-1:0] ROW_A = ADDR_W'(ARRAY_ROW);
    localparam logic [ADDR_W-1:0] COL_A = ADDR_W'(ARRAY_COL);

    state_t            state;
    logic [DIM_W-1:0]  m_dim;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] y_col_base;  // Y address of row tile 0 in the current column tile
    logic [ADDR_W-1:0] x_step;      // ARRAY_ROW * K
    logic [ADDR_W-1:0] y_step;      // ARRAY_ROW * N
    logic [ADDR_W-1:0] w_step;      // ARRAY_COL * K
    logic [DIM_W-1:0]  rows_left;   // M - m_idx*ARRAY_ROW
    logic [DIM_W-1:0]  cols_left;   // N - n_idx*ARRAY_COL
    logic [DIM_W-1:0]  rows_next;
    logic [DIM_W-1:0]  cols_next;
    logic              last_row;
    logic              last_col;
    logic              zero_job;

    assign sched_state_dbg = state;
    assign rows_next       = rows_left - ROW_D;
    assign cols_next       = cols_left - COL_D;
    assign last_row        = (rows_left <= ROW_D);
    assign last_col        = (cols_left <= COL_D);
    assign zero_job        = (cfg_m_dim == '0) || (cfg_n_dim == '0) || (cfg_k_dim == '0);

    // Valid extent of a tile: clamp the remaining rows/cols to the array size.
    function automatic logic [RV_W-1:0] row_ext(input logic [DIM_W-1:0] left);
        if (left >= ROW_D) return RV_W'(ARRAY_ROW);
        else               return left[RV_W-1:0];
    endfunction

    function automatic logic [CV_W-1:0] col_ext(input logic [DIM_W-1:0] left);
        if (left >= COL_D) return CV_W'(ARRAY_COL);
        else               return left[CV_W-1:0];
    endfunction

    // Scheduler FSM with all handshake and tile descriptor outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            ap_done         <= 1'b0;
            ap_idle         <= 1'b1;
            tile_start      <= 1'b0;
            tile_k_dim      <= '0;
            tile_m_idx      <= '0;
            tile_n_idx      <= '0;
            tile_x_addr     <= '0;
            tile_w_addr     <= '0;
            tile_y_addr     <= '0;
            tile_rows_valid <= '0;
            tile_cols_valid <= '0;
            m_dim           <= '0;
            x_base          <= '0;
            y_col_base      <= '0;
            x_step          <= '0;
            y_step          <= '0;
            w_step          <= '0;
            rows_left       <= '0;
            cols_left       <= '0;
        end else begin
            ap_done    <= 1'b0;
            tile_start <= 1'b0;
            ap_idle    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state <= S_LATCH;
                    end else begin
                        // Rises on the second IDLE cycle after a job.
                        ap_idle <= 1'b1;
                    end
                end
                S_LATCH: begin
                    m_dim           <= cfg_m_dim;
                    x_base          <= cfg_x_base;
                    y_col_base      <= cfg_y_base;
                    x_step          <= ROW_A * ADDR_W'(cfg_k_dim);
                    y_step          <= ROW_A * ADDR_W'(cfg_n_dim);
                    w_step          <= COL_A * ADDR_W'(cfg_k_dim);
                    rows_left       <= cfg_m_dim;
                    cols_left       <= cfg_n_dim;
                    tile_k_dim      <= cfg_k_dim;
                    tile_m_idx      <= '0;
                    tile_n_idx      <= '0;
                    tile_x_addr     <= cfg_x_base;
                    tile_w_addr     <= cfg_w_base;
                    tile_y_addr     <= cfg_y_base;
                    tile_rows_valid <= row_ext(cfg_m_dim);
                    tile_cols_valid <= col_ext(cfg_n_dim);
                    if (zero_job) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end else begin
                        state      <= S_ISSUE;
                        tile_start <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // tile_done here is ignored: the engine needs at least one cycle.
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tile_done) state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (last_row && last_col) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end else if (last_row) begin
                        // Next column tile, restart at row tile 0.
                        tile_m_idx      <= '0;
                        tile_n_idx      <= tile_n_idx + 1'b1;
                        rows_left       <= m_dim;
                        cols_left       <= cols_next;
                        tile_x_addr     <= x_base;
                        tile_w_addr     <= tile_w_addr + w_step;
                        tile_y_addr     <= y_col_base + COL_A;
                        y_col_base      <= y_col_base + COL_A;
                        tile_rows_valid <= row_ext(m_dim);
                        tile_cols_valid <= col_ext(cols_next);
                        state           <= S_ISSUE;
                        tile_start      <= 1'b1;
                    end else begin
                        // Next row tile under the same weight tile.
                        tile_m_idx      <= tile_m_idx + 1'b1;
                        rows_left       <= rows_next;
                        tile_x_addr     <= tile_x_addr + x_step;
                        tile_y_addr     <= tile_y_addr + y_step;
                        tile_rows_valid <= row_ext(rows_next);
                        state           <= S_ISSUE;
                        tile_start      <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Wait for ap_start to drop so a held start cannot retrigger.
                    if (!ap_start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    // Per-job counters: busy cycles (saturating) and accepted tile completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cycles <= '0;
            perf_tiles       <= '0;
        end else if (state == S_LATCH) begin
            perf_busy_cycles <= '0;
            perf_tiles       <= '0;
        end else if (state != S_IDLE) begin
            if (perf_busy_cycles != 32'hFFFF_FFFF) perf_busy_cycles <= perf_busy_cycles + 1'b1;
            if (state == S_WAIT && tile_done) perf_tiles <= perf_tiles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Bench for gemm_tile_scheduler: directed jobs, expected tile descriptors queued per job,
// a monitor that checks each tile_start against the queue, and a tile_done responder.
module tb_gemm_tile_scheduler;

    localparam int VW = 154;

    logic        clk = 1'b0;
    logic        rst;
    logic        ap_start;
    logic [15:0] cfg_m_dim, cfg_n_dim, cfg_k_dim;
    logic [31:0] cfg_x_base, cfg_w_base, cfg_y_base;
    logic        ap_done, ap_idle, tile_start, tile_done;
    logic [15:0] tile_k_dim, tile_m_idx, tile_n_idx;
    logic [31:0] tile_x_addr, tile_w_addr, tile_y_addr;
    logic [4:0]  tile_rows_valid, tile_cols_valid;
    logic [2:0]  sched_state_dbg;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_tiles;
`endif

    logic resp_done = 1'b0;
    logic spur_done = 1'b0;
    logic spur_issue = 1'b0;
    assign tile_done = resp_done | spur_done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int start_cnt = 0;
    logic [VW-1:0] exp_q[$];

    gemm_tile_scheduler dut (
        .clk(clk), .rst(rst), .ap_start(ap_start),
        .cfg_m_dim(cfg_m_dim), .cfg_n_dim(cfg_n_dim), .cfg_k_dim(cfg_k_dim),
        .cfg_x_base(cfg_x_base), .cfg_w_base(cfg_w_base), .cfg_y_base(cfg_y_base),
        .ap_done(ap_done), .ap_idle(ap_idle), .tile_start(tile_start), .tile_done(tile_done),
        .tile_k_dim(tile_k_dim), .tile_m_idx(tile_m_idx), .tile_n_idx(tile_n_idx),
        .tile_x_addr(tile_x_addr), .tile_w_addr(tile_w_addr), .tile_y_addr(tile_y_addr),
        .tile_rows_valid(tile_rows_valid), .tile_cols_valid(tile_cols_valid),
`ifdef SCHED_PERF_CNT_EN
        .perf_busy_cycles(perf_busy_cycles), .perf_tiles(perf_tiles),
`endif
        .sched_state_dbg(sched_state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] desc(input logic [15:0] m, input logic [15:0] n,
                                           input logic [31:0] x, input logic [31:0] w,
                                           input logic [31:0] y, input logic [4:0] rv,
                                           input logic [4:0] cv, input logic [15:0] k);
        return {m, n, x, w, y, rv, cv, k};
    endfunction

    function automatic logic [VW-1:0] act_desc();
        return {tile_m_idx, tile_n_idx, tile_x_addr, tile_w_addr, tile_y_addr,
                tile_rows_valid, tile_cols_valid, tile_k_dim};
    endfunction

    // Monitor: checks every tile_start against the expected queue, counts ap_done.
    always @(negedge clk) begin
        if (!rst) begin
            if (ap_done) done_cnt++;
            if (sched_state_dbg != 3'd0) check("idle_low", VW'(ap_idle), VW'(0));
            if (tile_start) begin
                start_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tile_unexpected act=%0h exp=none", act_desc());
                end else begin
                    check("tile", act_desc(), exp_q.pop_front());
                end
            end
        end
    end

    // Responder: acknowledges each tile about 5 cycles after tile_start.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tile_start) begin
                if (spur_issue) resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
                repeat (3) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_desc"}, act_desc(), VW'(0));
        check({name, "_ctl"}, VW'({ap_idle, ap_done, tile_start, sched_state_dbg}), VW'(6'b100_000));
    endtask

    task automatic set_cfg(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k,
                           input logic [31:0] xb, input logic [31:0] wb, input logic [31:0] yb);
        cfg_m_dim = m; cfg_n_dim = n; cfg_k_dim = k;
        cfg_x_base = xb; cfg_w_base = wb; cfg_y_base = yb;
    endtask

    // Runs one job: start, scramble cfg after LATCH, wait for ap_done, hold start, release.
    task automatic run_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k,
                           input logic [31:0] xb, input logic [31:0] wb, input logic [31:0] yb,
                           input int hold, input int exp_tiles);
        int base_d = done_cnt;
        int base_s = start_cnt;
        bit got = 1'b0;
        set_cfg(m, n, k, xb, wb, yb);
        ap_start = 1'b1;
        repeat (3) @(negedge clk);
        set_cfg(16'd1, 16'd1, 16'd3, 32'hDEAD_0000, 32'hDEAD_1000, 32'hDEAD_2000);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != base_d) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", VW'(got), VW'(1));
        repeat (hold) @(negedge clk);
        check("done_once", VW'(done_cnt - base_d), VW'(1));
        check("hold_in_done", VW'(sched_state_dbg), VW'(5));
        check("tile_count", VW'(start_cnt - base_s), VW'(exp_tiles));
        ap_start = 1'b0;
        repeat (3) @(negedge clk);
        check("back_idle", VW'({sched_state_dbg, ap_idle}), VW'(4'b000_1));
        check("queue_empty", VW'(exp_q.size()), VW'(0));
    endtask

    task automatic push_job1();
        exp_q.push_back(desc(0, 0, 32'h1000, 32'h2000, 32'h3000, 16, 16, 64));
        exp_q.push_back(desc(1, 0, 32'h1400, 32'h2000, 32'h3200, 16, 16, 64));
        exp_q.push_back(desc(0, 1, 32'h1000, 32'h2400, 32'h3010, 16, 16, 64));
        exp_q.push_back(desc(1, 1, 32'h1400, 32'h2400, 32'h3210, 16, 16, 64));
    endtask

    // Main stimulus
    initial begin
        int base_d;
        int base_s;
        bit got;
        rst = 1'b1;
        ap_start = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2x2 tiles, ap_start held high for a while in DONE
        push_job1();
        run_job(32, 32, 64, 32'h1000, 32'h2000, 32'h3000, 12, 4);

        // Spurious tile_done while idle
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_idle", VW'(sched_state_dbg), VW'(0));

        // Ragged 2x3 tiles with a tile_done also raised in every ISSUE cycle
        spur_issue = 1'b1;
        exp_q.push_back(desc(0, 0, 32'h100, 32'h200, 32'h400, 16, 16, 8));
        exp_q.push_back(desc(1, 0, 32'h180, 32'h200, 32'h680, 4, 16, 8));
        exp_q.push_back(desc(0, 1, 32'h100, 32'h280, 32'h410, 16, 16, 8));
        exp_q.push_back(desc(1, 1, 32'h180, 32'h280, 32'h690, 4, 16, 8));
        exp_q.push_back(desc(0, 2, 32'h100, 32'h300, 32'h420, 16, 8, 8));
        exp_q.push_back(desc(1, 2, 32'h180, 32'h300, 32'h6A0, 4, 8, 8));
        run_job(20, 40, 8, 32'h100, 32'h200, 32'h400, 2, 6);
        spur_issue = 1'b0;
`ifdef SCHED_PERF_CNT_EN
        check("perf_tiles_6", VW'(perf_tiles), VW'(6));
`endif

        // Address wrap modulo 2^32
        exp_q.push_back(desc(0, 0, 32'hFFFF_FF00, 32'h10, 32'hFFFF_FFF0, 16, 16, 16));
        exp_q.push_back(desc(1, 0, 32'h0000_0000, 32'h10, 32'h0000_00F0, 16, 16, 16));
        run_job(32, 16, 16, 32'hFFFF_FF00, 32'h10, 32'hFFFF_FFF0, 2, 2);

        // Zero-size job: no tiles, single ap_done
        run_job(0, 16, 16, 32'h100, 32'h200, 32'h300, 4, 0);

        // Reset while waiting on tile 2
        exp_q.push_back(desc(0, 0, 32'h1000, 32'h2000, 32'h3000, 16, 16, 64));
        exp_q.push_back(desc(1, 0, 32'h1400, 32'h2000, 32'h3200, 16, 16, 64));
        base_d = done_cnt;
        base_s = start_cnt;
        got = 1'b0;
        set_cfg(32, 32, 64, 32'h1000, 32'h2000, 32'h3000);
        ap_start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (start_cnt == base_s + 2) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("tile2_seen", VW'(got), VW'(1));
        repeat (2) @(negedge clk);
        check("in_wait", VW'(sched_state_dbg), VW'(3));
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        ap_start = 1'b0;
        repeat (8) @(negedge clk);
        check("no_done_reset", VW'(done_cnt - base_d), VW'(0));
        check("queue_empty_reset", VW'(exp_q.size()), VW'(0));
`ifdef SCHED_PERF_CNT_EN
        check("perf_reset", VW'(perf_tiles), VW'(0));
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fresh job after reset starts at (0,0)
        push_job1();
        run_job(32, 32, 64, 32'h1000, 32'h2000, 32'h3000, 2, 4);
`ifdef SCHED_PERF_CNT_EN
        check("perf_tiles_4", VW'(perf_tiles), VW'(4));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
